mips32_hazard_scoreboard: RTL and testbench
===========================================

Name: mips32_hazard_scoreboard

Overview:
- Parametrised register-dependency scoreboard for the pipelined MIPS32 core. It sits at the ID stage.
- It tracks which destination registers still have results in flight, and stalls issue on RAW and WAW hazards.
- Software therefore no longer has to insert dummy OR instructions between dependent instructions.
- Latencies, register count and optional forwarding are configurable per core generation.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register index width; must satisfy 2**AW >= NREGS.
- ALU_LAT, 3, stall cycles a dependent instruction sees after an ALU/ADDI producer, without forwarding.
- LD_LAT, 4, stall cycles after an LW producer, without forwarding.
- FWD_ALU_LAT, 0, ALU stall cycles when forwarding is compiled in.
- FWD_LD_LAT, 1, LW stall cycles when forwarding is compiled in.
- CW, 3, per-register countdown width; must hold max(ALU_LAT, LD_LAT).

Ports:
- clk  input  1  single core clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- issue_valid  input  1  ID stage presents an instruction.
- issue_rs  input  AW  first source register.
- issue_rs_used  input  1  rs is read by this instruction.
- issue_rt  input  AW  second source register.
- issue_rt_used  input  1  rt is read by this instruction.
- issue_rd  input  AW  destination register.
- issue_wr  input  1  instruction writes issue_rd.
- issue_is_load  input  1  instruction is LW.
- flush  input  1  taken branch; kills the instruction currently in ID.
- stall  output  1  hold IF/ID this cycle (combinational).
- issue_accept  output  1  instruction leaves ID this cycle (combinational).
- busy_mask  output  NREGS  registered; bit i set when cnt[i] != 0.
- stall_count  output  16  registered count of stall cycles, saturating.

Behaviour:
- State: one CW-bit countdown cnt[i] per register. cnt[0] is never loaded and always reads 0.
- Reset (asynchronous, any time, including mid-stall):
  - all cnt = 0, busy_mask = 0, stall_count = 0.
  - stall and issue_accept fall to 0 combinationally once the counters clear.
- Hazard terms:
  - raw = (rs_used & cnt[rs] != 0) | (rt_used & cnt[rt] != 0).
  - waw = issue_wr & rd != 0 & cnt[rd] != 0.
- Outputs:
  - stall = issue_valid & !flush & (raw | waw).
  - issue_accept = issue_valid & !flush & !(raw | waw).
- Each clock:
  - every nonzero cnt decrements by 1.
  - if issue_accept & issue_wr & rd != 0: cnt[rd] loads LD_LAT (is_load) or ALU_LAT. The load overrides the decrement for that register.
- Timing:
  - Producer accepted at cycle t.
  - Dependent instruction is presented continuously from t+1.
  - Result: exactly LAT stall cycles (t+1..t+LAT); accept at t+LAT+1.
- Independent instructions are never stalled, even while other registers are busy.
- A load value of 0 means the register is not tracked: no stall.
- Register index 0:
  - reads of register 0 never stall.
  - writes to register 0 never set busy.
- Flush:
  - forces stall = 0 and issue_accept = 0 that cycle; no counter is loaded.
  - in-flight counters keep decrementing; older producers still complete.
- Simultaneous rs = rt = busy register: a single stall, no double counting.
- Register indices >= NREGS are treated as not busy.
- stall_count increments on every cycle stall = 1 and holds at 16'hFFFF.
- busy_mask reflects post-edge counter state.

Optional Feature:
- Macro MIPS32_HAZARD_FWD_EN.
- When defined:
  - counters load FWD_ALU_LAT / FWD_LD_LAT instead of ALU_LAT / LD_LAT.
  - defaults model EX/MEM forwarding: ALU chains issue back-to-back; load-use costs 1 bubble.
  - WAW checking is unchanged.
- When undefined: no-forwarding latencies as above; the forwarding parameters are ignored.

Test Plan:
- ADDI R1 accepted at cycle 0, ADD R4,R1,R2 presented from cycle 1 -> stall=1 on cycles 1-3, accept on cycle 4, stall_count=3.
- LW R8 accepted, then SW using R8 -> 4 stall cycles.
  - With MIPS32_HAZARD_FWD_EN: 1 stall cycle.
  - With MIPS32_HAZARD_FWD_EN, ADDI->ADD: 0 stalls.
- Write R0, then read R0 next cycle -> no stall; busy_mask=0.
- ADDI R5, then independent ADD R6,R1,R2 -> accepted immediately, busy_mask bit5 set for 3 cycles.
- R7 busy with cnt=2, flush asserted with dependent in ID -> stall=0 and accept=0 that cycle. R7 clears on schedule.
- rst asserted mid-stall (cnt[3]=2) -> busy_mask=0, stall=0 immediately, stall_count=0. Force stall_count near 16'hFFFF -> it saturates.

Source files
------------

// File: rtl/mips32_hazard_scoreboard.sv
// mips32_hazard_scoreboard
// ID-stage register dependency scoreboard. Each architectural register owns
// a small countdown that is loaded when a writer issues and counts down to
// zero. A nonzero count marks the register as having a result in flight.
// Issue stalls on RAW (source busy) and WAW (destination busy) hazards.
//
// Build option: define MIPS32_HAZARD_FWD_EN to load the forwarding
// latencies (FWD_ALU_LAT / FWD_LD_LAT) instead of ALU_LAT / LD_LAT.
//
// Handshake: the ID stage holds issue_* stable while issue_valid is high.
// In any cycle with issue_valid=1 and flush=0, exactly one of stall or
// issue_accept is 1. issue_accept=1 means the instruction leaves ID at the
// next rising edge; stall=1 means IF/ID must hold. flush kills the
// instruction in ID, so neither output is asserted that cycle.
module mips32_hazard_scoreboard #(
  parameter int NREGS       = 32,
  parameter int AW          = 5,
  parameter int ALU_LAT     = 3,
  parameter int LD_LAT      = 4,
  parameter int FWD_ALU_LAT = 0,
  parameter int FWD_LD_LAT  = 1,
  parameter int CW          = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs,
  input  logic             issue_rs_used,
  input  logic [AW-1:0]    issue_rt,
  input  logic             issue_rt_used,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_wr,
  input  logic             issue_is_load,
  input  logic             flush,
  output logic             stall,
  output logic             issue_accept,
  output logic [NREGS-1:0] busy_mask,
  output logic [15:0]      stall_count
);

`ifdef MIPS32_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Values loaded into a destination counter when its writer issues.
  localparam logic [CW-1:0] ALU_LOAD = CW'(FWD ? FWD_ALU_LAT : ALU_LAT);
  localparam logic [CW-1:0] LD_LOAD  = CW'(FWD ? FWD_LD_LAT  : LD_LAT);

  logic [CW-1:0]    cnt      [NREGS];
  logic [CW-1:0]    cnt_next [NREGS];
  logic [NREGS-1:0] busy_next;

  logic rs_busy;
  logic rt_busy;
  logic rd_busy;
  logic hazard;
  logic live;
  logic load_en;
  logic [CW-1:0] load_val;

  // Look up the busy state of the three referenced registers. Register 0
  // and indices outside the register file are never busy.
  always_comb begin
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    rd_busy = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (issue_rs == AW'(i)) rs_busy = (cnt[i] != '0);
      if (issue_rt == AW'(i)) rt_busy = (cnt[i] != '0);
      if (issue_rd == AW'(i)) rd_busy = (cnt[i] != '0);
    end
  end

  // Hazard decision and issue handshake. Reset forces both outputs low so
  // nothing is accepted while the counters are being cleared.
  always_comb begin
    hazard       = (issue_rs_used & rs_busy) |
                   (issue_rt_used & rt_busy) |
                   (issue_wr & (issue_rd != '0) & rd_busy);
    live         = issue_valid & ~flush & ~rst;
    stall        = live & hazard;
    issue_accept = live & ~hazard;
    load_en      = issue_accept & issue_wr & (issue_rd != '0);
    load_val     = issue_is_load ? LD_LOAD : ALU_LOAD;
  end

  // Next counter state: every busy counter decrements; a newly issued
  // writer reloads its destination, overriding the decrement.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_next[i] = (cnt[i] != '0) ? (cnt[i] - CW'(1)) : '0;
      if ((i != 0) && load_en && (issue_rd == AW'(i))) begin
        cnt_next[i] = load_val;
      end
      busy_next[i] = (cnt_next[i] != '0);
    end
  end

  // Counter array and registered busy mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i] <= '0;
      end
      busy_mask <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i] <= cnt_next[i];
      end
      busy_mask <= busy_next;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mips32_hazard_scoreboard.sv
// tb_mips32_hazard_scoreboard
// Self-checking bench for mips32_hazard_scoreboard. Expected behaviour comes
// from a reference model that records, per register, the first cycle at
// which it is free again, plus a saturating count of stalled cycles.
// Honours MIPS32_HAZARD_FWD_EN the same way the design does.
module tb_mips32_hazard_scoreboard;

  localparam int NREGS       = 32;
  localparam int AW          = 5;
  localparam int CW          = 3;
  localparam int ALU_LAT     = 3;
  localparam int LD_LAT      = 4;
  localparam int FWD_ALU_LAT = 0;
  localparam int FWD_LD_LAT  = 1;
`ifdef MIPS32_HAZARD_FWD_EN
  localparam int ALU_L = FWD_ALU_LAT;
  localparam int LD_L  = FWD_LD_LAT;
`else
  localparam int ALU_L = ALU_LAT;
  localparam int LD_L  = LD_LAT;
`endif

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic [AW-1:0]    issue_rs;
  logic             issue_rs_used;
  logic [AW-1:0]    issue_rt;
  logic             issue_rt_used;
  logic [AW-1:0]    issue_rd;
  logic             issue_wr;
  logic             issue_is_load;
  logic             flush;
  logic             stall;
  logic             issue_accept;
  logic [NREGS-1:0] busy_mask;
  logic [15:0]      stall_count;

  mips32_hazard_scoreboard #(
    .NREGS(NREGS), .AW(AW), .ALU_LAT(ALU_LAT), .LD_LAT(LD_LAT),
    .FWD_ALU_LAT(FWD_ALU_LAT), .FWD_LD_LAT(FWD_LD_LAT), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
    .issue_rt(issue_rt), .issue_rt_used(issue_rt_used),
    .issue_rd(issue_rd), .issue_wr(issue_wr),
    .issue_is_load(issue_is_load), .flush(flush),
    .stall(stall), .issue_accept(issue_accept),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ready [NREGS];
  int exp_stall_cnt = 0;
  logic [NREGS+1:0] exp_q[$];

  logic             last_stall;
  logic             last_acc;
  logic [NREGS-1:0] last_mask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_busy(input int r);
    return (r != 0) && (r < NREGS) && (cyc < ready[r]);
  endfunction

  function automatic logic [NREGS-1:0] bit_if(input bit cond, input int r);
    logic [NREGS-1:0] m;
    m = '0;
    if (cond) m[r] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) ready[i] = 0;
    exp_stall_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int rs, input logic rsu,
                       input int rt, input logic rtu, input int rd,
                       input logic wr, input logic ld, input logic fl);
    issue_valid   = v;
    issue_rs      = AW'(rs);
    issue_rs_used = rsu;
    issue_rt      = AW'(rt);
    issue_rt_used = rtu;
    issue_rd      = AW'(rd);
    issue_wr      = wr;
    issue_is_load = ld;
    flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at the falling edge with inputs already driven: checks the DUT
  // against the model, advances the model and moves to the next falling edge.
  task automatic step(input string tag);
    bit raw, waw, e_stall, e_acc;
    logic [NREGS-1:0] m_mask;
    logic [NREGS+1:0] e;
    #1;
    raw = (issue_rs_used && m_busy(int'(issue_rs))) ||
          (issue_rt_used && m_busy(int'(issue_rt)));
    waw = issue_wr && (issue_rd != '0) && m_busy(int'(issue_rd));
    e_stall = issue_valid && !flush && (raw || waw);
    e_acc   = issue_valid && !flush && !(raw || waw);
    for (int r = 0; r < NREGS; r++) m_mask[r] = m_busy(r);
    exp_q.push_back({m_mask, e_stall, e_acc});
    last_stall = stall;
    last_acc   = issue_accept;
    last_mask  = busy_mask;
    e = exp_q.pop_front();
    check({tag, "_outs"}, 64'({busy_mask, stall, issue_accept}), 64'(e));
    check({tag, "_stall_count"}, 64'(stall_count), 64'(exp_stall_cnt));
    if (e_stall && exp_stall_cnt < 65535) exp_stall_cnt++;
    if (e_acc && issue_wr && issue_rd != '0)
      ready[int'(issue_rd)] = cyc + 1 + (issue_is_load ? LD_L : ALU_L);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Keep the current instruction presented until accepted; count stalls.
  task automatic until_accept(input string tag, input int exp_n);
    int n;
    bit done;
    n = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(tag);
      if (last_acc) done = 1;
      else if (last_stall) n++;
    end
    check({tag, "_accepted"}, 64'(done), 64'd1);
    check({tag, "_stall_cycles"}, 64'(n), 64'(exp_n));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_outs", 64'({busy_mask, stall, issue_accept}), 64'd0);
    check("reset_stall_count", 64'(stall_count), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic v; int rs; logic rsu; int rt; logic rtu; int rd;
    logic wr; logic ld; logic fl;
    logic e_stall; logic e_acc; logic [NREGS-1:0] e_mask;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // From a clean state at table cycle 0: ADDI R5 at cycle 2, independent
    // ADD R6 at cycle 3, so R5 is busy for cycles 3..2+ALU_L and R6 for
    // cycles 4..3+ALU_L.
    tbl[0] = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, '0};                 // write R0
    tbl[1] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, '0};                 // read R0
    tbl[2] = '{1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 1, '0};                 // ADDI R5
    tbl[3] = '{1, 1, 1, 2, 1, 6, 1, 0, 0, 0, 1, bit_if(ALU_L >= 1, 5)};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               bit_if(ALU_L >= 2, 5) | bit_if(ALU_L >= 1, 6)};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               bit_if(ALU_L >= 3, 5) | bit_if(ALU_L >= 2, 6)};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               bit_if(ALU_L >= 4, 5) | bit_if(ALU_L >= 3, 6)};
    tbl[7] = '{1, 6, 1, 0, 0, 9, 1, 0, 1, 0, 0,                       // flushed
               bit_if(ALU_L >= 5, 5) | bit_if(ALU_L >= 4, 6)};

    rst = 1'b1;
    idle();
    @(negedge clk);
    do_reset();

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu,
            tbl[i].rd, tbl[i].wr, tbl[i].ld, tbl[i].fl);
      step($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_vec", i),
            64'({last_mask, last_stall, last_acc}),
            64'({tbl[i].e_mask, tbl[i].e_stall, tbl[i].e_acc}));
    end
    idle();
    repeat (6) step("drain");

    // ADDI R1 then dependent ADD R4,R1,R2.
    do_reset();
    drive(1, 2, 1, 0, 0, 1, 1, 0, 0);
    step("addi_r1");
    drive(1, 1, 1, 2, 1, 4, 1, 0, 0);
    until_accept("alu_raw", ALU_L);
    check("alu_raw_count", 64'(stall_count), 64'(ALU_L));
    idle();
    repeat (6) step("drain");

    // LW R8 then SW reading R8.
    drive(1, 29, 1, 0, 0, 8, 1, 1, 0);
    step("lw_r8");
    drive(1, 29, 1, 8, 1, 0, 0, 0, 0);
    until_accept("load_use", LD_L);
    idle();
    repeat (6) step("drain");

    // Flush while a dependent of R7 sits in ID.
    drive(1, 1, 1, 0, 0, 7, 1, 0, 0);
    step("addi_r7");
    drive(1, 7, 1, 0, 1, 10, 1, 0, 0);
    step("dep_r7");
    drive(1, 7, 1, 0, 1, 10, 1, 0, 1);
    step("flush_r7");
    check("flush_stall_acc", 64'({last_stall, last_acc}), 64'd0);
    drive(1, 7, 1, 0, 1, 10, 1, 0, 0);
    until_accept("after_flush", (ALU_L > 2) ? ALU_L - 2 : 0);
    idle();
    repeat (6) step("drain");

    // rs = rt = same busy register: one stall per cycle.
    drive(1, 1, 1, 0, 0, 3, 1, 0, 0);
    step("addi_r3");
    drive(1, 3, 1, 3, 1, 5, 1, 0, 0);
    until_accept("rs_eq_rt", ALU_L);
    idle();
    repeat (6) step("drain");

    // WAW: back-to-back writers of R9.
    drive(1, 1, 1, 0, 0, 9, 1, 0, 0);
    step("addi_r9");
    drive(1, 2, 1, 0, 0, 9, 1, 0, 0);
    until_accept("waw_r9", ALU_L);
    idle();
    repeat (6) step("drain");

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      drive(1'($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0));
      step("rand");
    end
    idle();
    repeat (6) step("drain");

    // Asynchronous reset in the middle of a stall.
    drive(1, 1, 1, 0, 0, 3, 1, 0, 0);
    step("addi_r3b");
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
    step("dep_r3b");
    #1;
    rst = 1'b1;
    #1;
    check("midstall_reset", 64'({busy_mask, stall, issue_accept}), 64'd0);
    check("midstall_reset_count", 64'(stall_count), 64'd0);
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step("post_reset");

    // Saturation of stall_count from a preset value near the top.
    force dut.stall_count = 16'hFFFC;
    #1;
    release dut.stall_count;
    exp_stall_cnt = 65532;
    drive(1, 11, 1, 0, 0, 11, 1, 1, 0);
    repeat (20) step("saturate");
    check("stall_count_sat", 64'(stall_count), 64'hFFFF);
    idle();
    repeat (6) step("drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
